// File: rtl/izhikevich_scheduler.sv
// Time-multiplexes one Izhikevich core over NUM_NEURONS neurons, holding per-neuron v/w/current.
// Latency: start at cycle T -> busy T+1..T+3*NUM_NEURONS, done pulse at T+3*NUM_NEURONS+1.
// No backpressure: start/init are accepted only in IDLE and dropped otherwise (no queuing).
// Optional feature macro: SCHED_SPIKE_COUNT_EN adds per-neuron saturating spike counters.
module izhikevich_scheduler #(
    parameter int N           = 32,
    parameter int Q           = 16,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic [N-1:0]             v_init,
    input  logic [N-1:0]             w_init,
    input  logic                     start,
    input  logic [NUM_NEURONS*N-1:0] i_flat,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_NEURONS-1:0]   spikes,
    output logic [15:0]              step_count,
    output logic                     core_load,
    output logic                     core_apply,
    output logic [N-1:0]             core_v_init,
    output logic [N-1:0]             core_w_init,
    output logic [N-1:0]             core_i,
    input  logic [N-1:0]             core_voltage,
    input  logic [N-1:0]             core_w,
    input  logic                     core_spike
`ifdef SCHED_SPIKE_COUNT_EN
    ,
    input  logic [IDX_W-1:0]         cnt_sel,
    input  logic                     cnt_clr,
    output logic [15:0]              cnt_out
`endif
);

    // Q only describes the fixed-point format of the words passing through; reject nonsense sizes.
    if (Q >= N || NUM_NEURONS < 1) begin : g_param_check
        $error("izhikevich_scheduler: invalid Q/N/NUM_NEURONS combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_FIN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [N-1:0]           v_mem   [NUM_NEURONS];
    logic [N-1:0]           w_mem   [NUM_NEURONS];
    logic [N-1:0]           cur_mem [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spk_shadow;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; init has priority over start in IDLE.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        core_load  = 1'b0;
        core_apply = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !init) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                core_load = 1'b1;
                state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy       = 1'b1;
                core_apply = 1'b1;
                state_nxt  = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                state_nxt = (idx == LAST_IDX) ? S_FIN : S_LOAD;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Neuron state, current latch, index walk and atomic result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            spk_shadow <= '0;
            spikes     <= '0;
            step_count <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k]   <= '0;
                w_mem[k]   <= '0;
                cur_mem[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (init) begin
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            v_mem[k] <= v_init;
                            w_mem[k] <= w_init;
                        end
                    end else if (start) begin
                        idx <= '0;
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            cur_mem[k] <= i_flat[k*N +: N];
                        end
                    end
                end
                S_CAPTURE: begin
                    v_mem[idx]      <= core_voltage;
                    w_mem[idx]      <= core_w;
                    spk_shadow[idx] <= core_spike;
                    // Wrap to 0 after the last neuron so IDLE presents neuron 0.
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                S_FIN: begin
                    spikes     <= spk_shadow;
                    step_count <= step_count + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign core_v_init = v_mem[idx];
    assign core_w_init = w_mem[idx];
    assign core_i      = cur_mem[idx];

`ifdef SCHED_SPIKE_COUNT_EN
    logic [15:0] spk_cnt [NUM_NEURONS];

    // Saturating per-neuron spike counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                spk_cnt[k] <= '0;
            end
        end else if (state == S_CAPTURE && core_spike && spk_cnt[idx] != 16'hFFFF) begin
            spk_cnt[idx] <= spk_cnt[idx] + 16'd1;
        end
    end

    assign cnt_out = spk_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Self-checking bench for izhikevich_scheduler with a simple integrate-and-fire core stub.
// A per-timestep behavioural model predicts strobes, core operands, spikes and step_count.
// Directed scenarios pin the model with literal values, then random traffic runs against it.
module tb_izhikevich_scheduler;
    localparam int N  = 32;
    localparam int NN = 8;
    localparam int IW = 3;
    localparam int FIN_PH = 3 * NN + 1;
    localparam logic [31:0] VTH  = 32'h001E0000;
    localparam logic [31:0] CR   = 32'hFFBF0000;
    localparam logic [31:0] DR   = 32'h00080000;
    localparam logic [31:0] WINC = 32'h00000100;

    logic            clk = 1'b0;
    logic            rst, init, start;
    logic [N-1:0]    v_init, w_init;
    logic [NN*N-1:0] i_flat;
    logic            busy, done, core_load, core_apply;
    logic [NN-1:0]   spikes;
    logic [15:0]     step_count;
    logic [N-1:0]    core_v_init, core_w_init, core_i;
    logic [N-1:0]    core_voltage, core_w;
    logic            core_spike;
`ifdef SCHED_SPIKE_COUNT_EN
    logic [IW-1:0]   cnt_sel;
    logic            cnt_clr;
    logic [15:0]     cnt_out;
`endif

    izhikevich_scheduler #(.N(N), .Q(16), .NUM_NEURONS(NN), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .init(init), .v_init(v_init), .w_init(w_init),
        .start(start), .i_flat(i_flat), .busy(busy), .done(done), .spikes(spikes),
        .step_count(step_count), .core_load(core_load), .core_apply(core_apply),
        .core_v_init(core_v_init), .core_w_init(core_w_init), .core_i(core_i),
        .core_voltage(core_voltage), .core_w(core_w), .core_spike(core_spike)
`ifdef SCHED_SPIKE_COUNT_EN
        , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Neuron update of the stand-in core: {spike, v', w'}.
    function automatic logic [64:0] neuron_f(input logic [31:0] v, input logic [31:0] w,
                                             input logic [31:0] i);
        logic [31:0] nv;
        nv = v + i;
        if ($signed(nv) >= $signed(VTH)) return {1'b1, CR, w + DR};
        return {1'b0, nv, w + WINC};
    endfunction

    // Core stub: load on core_load, one integration step on core_apply.
    logic [64:0] stub_r;
    always @(posedge clk) begin
        if (core_load) begin
            core_voltage <= core_v_init;
            core_w       <= core_w_init;
            core_spike   <= 1'b0;
        end else if (core_apply) begin
            stub_r = neuron_f(core_voltage, core_w, core_i);
            core_spike   <= stub_r[64];
            core_voltage <= stub_r[63:32];
            core_w       <= stub_r[31:0];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: whole timestep computed at acceptance, published at the end of FIN.
    logic [31:0] mv [NN];
    logic [31:0] mw [NN];
    logic [31:0] mcur [NN];
    logic [31:0] nv [NN];
    logic [31:0] nw [NN];
    logic [NN-1:0] mspk, nspk;
    logic [15:0] mstep;
    logic [15:0] mcnt [NN];
    int  ph = 0;
    bit  m_active = 1'b0;
    logic [64:0] mr;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            ph = 0;
            mspk = '0;
            mstep = '0;
            for (int k = 0; k < NN; k++) begin
                mv[k] = '0; mw[k] = '0; mcur[k] = '0; mcnt[k] = '0;
            end
        end else begin
            if (m_active) begin
                if (ph == FIN_PH) begin
                    for (int k = 0; k < NN; k++) begin
                        mv[k] = nv[k];
                        mw[k] = nw[k];
                        if (nspk[k] && mcnt[k] != 16'hFFFF) mcnt[k] = mcnt[k] + 16'd1;
                    end
                    mspk = nspk;
                    mstep = mstep + 16'd1;
                    m_active = 1'b0;
                end else begin
                    ph++;
                end
            end else if (init) begin
                for (int k = 0; k < NN; k++) begin
                    mv[k] = v_init; mw[k] = w_init;
                end
            end else if (start) begin
                for (int k = 0; k < NN; k++) begin
                    mcur[k] = i_flat[k*N +: N];
                    mr = neuron_f(mv[k], mw[k], mcur[k]);
                    nspk[k] = mr[64];
                    nv[k] = mr[63:32];
                    nw[k] = mr[31:0];
                end
                m_active = 1'b1;
                ph = 1;
            end
`ifdef SCHED_SPIKE_COUNT_EN
            if (cnt_clr) begin
                for (int k = 0; k < NN; k++) mcnt[k] = '0;
            end
`endif
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    bit e_busy, e_done, e_load, e_apply;
    int e_k;
    always @(negedge clk) begin
        if (chk_en) begin
            e_busy  = m_active && ph <= 3 * NN;
            e_done  = m_active && ph == FIN_PH;
            e_load  = e_busy && ((ph - 1) % 3 == 0);
            e_apply = e_busy && ((ph - 1) % 3 == 1);
            e_k     = (ph - 1) / 3;
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("core_load", 64'(core_load), 64'(e_load));
            chk("core_apply", 64'(core_apply), 64'(e_apply));
            chk("spikes", 64'(spikes), 64'(mspk));
            chk("step_count", 64'(step_count), 64'(mstep));
            if (e_load || e_apply) chk("core_i", 64'(core_i), 64'(mcur[e_k]));
            if (e_load) begin
                chk("core_v_init", 64'(core_v_init), 64'(mv[e_k]));
                chk("core_w_init", 64'(core_w_init), 64'(mw[e_k]));
            end
            if (!m_active) begin
                chk("idle_v_init", 64'(core_v_init), 64'(mv[0]));
                chk("idle_w_init", 64'(core_w_init), 64'(mw[0]));
                chk("idle_core_i", 64'(core_i), 64'(mcur[0]));
`ifdef SCHED_SPIKE_COUNT_EN
                chk("cnt_out", 64'(cnt_out), 64'(mcnt[cnt_sel]));
`endif
            end
        end
    end

    // Load/apply counting and literal capture of operands during LOAD.
    int nload = 0, napply = 0, bad_lit = 0;
    bit lit_mon = 1'b0;
    logic [31:0] n3v;
    always @(negedge clk) begin
        if (core_apply) napply++;
        if (core_load) begin
            if (nload == 3) n3v = core_v_init;
            if (lit_mon && (core_v_init !== 32'hFFBF0000 || core_w_init !== 32'hFFF30000)) bad_lit++;
            nload++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int t0, output int lat);
        int at;
        at = -1;
        for (int k = 0; k < 80 && at < 0; k++) begin
            @(negedge clk);
            if (done) at = cyc;
        end
        if (at < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no done within 80 cycles (cycle %0d)", cyc);
            lat = -1;
        end else begin
            lat = at - t0;
        end
        tick();
    endtask

    task automatic run_step(input logic [NN*N-1:0] cur, output int lat);
        int t0;
        nload = 0;
        napply = 0;
        i_flat = cur;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        wait_done(t0, lat);
    endtask

    logic [NN*N-1:0] cur3;
    int lat, nsteps, t0, nd, s3;

    initial begin
        rst = 1'b1; init = 1'b0; start = 1'b0;
        v_init = '0; w_init = '0; i_flat = '0;
`ifdef SCHED_SPIKE_COUNT_EN
        cnt_sel = 3'd3; cnt_clr = 1'b0;
`endif
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_spikes", 64'(spikes), 64'd0);
        chk("rst_step_count", 64'(step_count), 64'd0);
        chk("rst_core_load", 64'(core_load), 64'd0);
        chk("rst_core_apply", 64'(core_apply), 64'd0);
        tick();

        // Broadcast init, then a zero-current timestep.
        v_init = 32'hFFBF0000;
        w_init = 32'hFFF30000;
        init = 1'b1;
        tick();
        init = 1'b0;
        lit_mon = 1'b1;
        bad_lit = 0;
        run_step('0, lat);
        lit_mon = 1'b0;
        chk("init_operands_in_load", 64'(bad_lit), 64'd0);
        chk("step_latency", 64'(lat), 64'd25);
        chk("load_pulses", 64'(nload), 64'd8);
        chk("apply_pulses", 64'(napply), 64'd8);
        chk("step_count_1", 64'(step_count), 64'd1);

        // Neuron 3 driven at +10.0 per step: -65 crosses 30 on the tenth step.
        cur3 = '0;
        cur3[3*N +: N] = 32'h000A0000;
        nsteps = 0;
        while (nsteps < 15 && spikes == '0) begin
            run_step(cur3, lat);
            nsteps++;
        end
        chk("first_spike_vec", 64'(spikes), 64'h08);
        chk("steps_to_spike", 64'(nsteps), 64'd10);
        run_step(cur3, lat);
        chk("n3_reload_is_c", 64'(n3v), 64'(CR));
        chk("spike_cleared", 64'(spikes), 64'h00);

        // start/init pulses mid-step are dropped; i_flat changes are ignored.
        i_flat = cur3;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; init = 1'b1; v_init = '0; i_flat = '1;
        tick();
        start = 1'b0; init = 1'b0;
        repeat (6) tick();
        init = 1'b1;
        tick();
        init = 1'b0;
        wait_done(t0, lat);
        chk("midstep_latency", 64'(lat), 64'd25);
        chk("step_count_13", 64'(step_count), 64'd13);

`ifdef SCHED_SPIKE_COUNT_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        s3 = 0;
        for (int k = 0; k < 40 && s3 < 3; k++) begin
            run_step(cur3, lat);
            if (spikes[3]) s3++;
        end
        @(negedge clk);
        chk("cnt_three_spikes", 64'(cnt_out), 64'd3);
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_cleared", 64'(cnt_out), 64'd0);
        tick();
        dut.spk_cnt[3] = 16'hFFFF;
        mcnt[3] = 16'hFFFF;
        s3 = 0;
        for (int k = 0; k < 15 && s3 < 1; k++) begin
            run_step(cur3, lat);
            if (spikes[3]) s3++;
        end
        @(negedge clk);
        chk("cnt_saturated", 64'(cnt_out), 64'hFFFF);
        tick();
`endif

        // Reset at T+10 aborts the step without a done pulse.
        i_flat = cur3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_step_count", 64'(step_count), 64'd0);
        chk("abort_v_state", 64'(core_v_init), 64'd0);
        chk("abort_w_state", 64'(core_w_init), 64'd0);
        tick();

        // Random traffic: frequent starts, occasional init/rst, i_flat churning every cycle.
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            init  = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 2) == 0);
            if (init) begin
                v_init = (32'd0 - 32'($urandom_range(0, 80))) << 16;
                w_init = (32'd0 - 32'($urandom_range(0, 20))) << 16;
            end
            for (int k = 0; k < NN; k++) begin
                i_flat[k*N +: N] = 32'($urandom_range(0, 12)) << 16;
            end
            tick();
        end
        rst = 1'b0; init = 1'b0; start = 1'b0;
        repeat (30) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
